// File: rtl/simon_pkg.sv
// Shared encodings between the Simon control FSM and the Simon datapath.
// The controller drives st with these mode values and mux_control with the LED sources.
package simon_pkg;

   typedef enum logic [1:0] {
      ST_INPUT    = 2'd0,
      ST_PLAYBACK = 2'd1,
      ST_REPEAT   = 2'd2,
      ST_DONE     = 2'd3
   } simon_st_e;

   localparam logic LED_FROM_PATTERN = 1'b0;
   localparam logic LED_FROM_MEM     = 1'b1;

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern storage for the Simon game: DEPTH x WIDTH entries with one synchronous
// write port and one asynchronous read port. Contents are deliberately not reset.
module simon_pattern_mem #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: stores the pattern sequence, steps the read pointer through
// playback/repeat/done modes and returns the status flags the controller branches on.
module simon_datapath
   import simon_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             level,
   input  logic [WIDTH-1:0] pattern,
   input  logic             mux_control,
   input  logic [1:0]       st,
   input  logic             clear,
   input  logic             increase,
   input  logic             w_en,
   input  logic             done,
   output logic             InputValid,
   output logic             RWeq,
   output logic             InputEqPat,
   output logic [WIDTH-1:0] pad_leds
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW:0]      cnt;
   logic [AW-1:0]    rptr;
   logic             lvl_q;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_we;
   logic             pattern_legal;
   simon_st_e        st_e;

   // done only marks game over for the controller; nothing here depends on it.
   logic unused_done;
   assign unused_done = done;

   assign st_e = simon_st_e'(st);

   simon_pattern_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cnt[AW-1:0]),
      .wdata (pattern),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   // At level 1 only one-hot switch settings are legal, so all-zero is rejected.
   assign pattern_legal = lvl_q ? $onehot(pattern) : 1'b1;
   assign InputValid    = (cnt < CNT_FULL) && pattern_legal;
   assign RWeq          = (rptr == cnt[AW-1:0]);
   assign InputEqPat    = (pattern == mem_rdata);
   assign pad_leds      = (mux_control == LED_FROM_MEM) ? mem_rdata : pattern;

   assign mem_we = (st_e == ST_INPUT) && w_en && InputValid && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         rptr  <= '0;
         lvl_q <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         rptr  <= '0;
         lvl_q <= level;
      end else begin
         case (st_e)
            ST_INPUT: begin
               rptr <= '0;
            end
            ST_PLAYBACK, ST_DONE: begin
               rptr <= RWeq ? '0 : rptr + 1'b1;
            end
            ST_REPEAT: begin
               // A full memory is the win condition; cnt saturates there.
               if (increase) begin
                  rptr <= '0;
                  if (cnt != CNT_FULL) begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (InputEqPat) begin
                  rptr <= rptr + 1'b1;
               end
            end
            default: begin
               rptr <= rptr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: a DEPTH=64 instance for the game scenarios
// and a DEPTH=4 instance sharing the same stimulus for the full-memory boundary.
module tb_simon_datapath;

   logic       clk;
   logic       rst_n;
   logic       level;
   logic [3:0] pattern;
   logic       mux_control;
   logic [1:0] st;
   logic       clear;
   logic       increase;
   logic       w_en;
   logic       done;

   logic       input_valid, rw_eq, input_eq_pat;
   logic [3:0] pad_leds;
   logic       s_input_valid, s_rw_eq, s_input_eq_pat;
   logic [3:0] s_pad_leds;

   int n_total = 0;
   int n_bad   = 0;

   logic [3:0] exp_q[$];
   logic [3:0] m_mem [64];

   simon_datapath #(.WIDTH(4), .DEPTH(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .level       (level),
      .pattern     (pattern),
      .mux_control (mux_control),
      .st          (st),
      .clear       (clear),
      .increase    (increase),
      .w_en        (w_en),
      .done        (done),
      .InputValid  (input_valid),
      .RWeq        (rw_eq),
      .InputEqPat  (input_eq_pat),
      .pad_leds    (pad_leds)
   );

   simon_datapath #(.WIDTH(4), .DEPTH(4)) dut_s (
      .clk         (clk),
      .rst_n       (rst_n),
      .level       (level),
      .pattern     (pattern),
      .mux_control (mux_control),
      .st          (st),
      .clear       (clear),
      .increase    (increase),
      .w_en        (w_en),
      .done        (done),
      .InputValid  (s_input_valid),
      .RWeq        (s_rw_eq),
      .InputEqPat  (s_input_eq_pat),
      .pad_leds    (s_pad_leds)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      level       = 1'b0;
      pattern     = 4'd0;
      mux_control = 1'b0;
      st          = 2'd0;
      clear       = 1'b0;
      increase    = 1'b0;
      w_en        = 1'b0;
      done        = 1'b0;
   endtask

   task automatic do_clear(input logic lvl);
      idle_inputs();
      level = lvl;
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
   endtask

   task automatic write_entry(input logic [3:0] val, input int addr);
      st      = 2'd0;
      w_en    = 1'b1;
      pattern = val;
      m_mem[addr] = val;
      next_cycle();
      w_en    = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      n_total++;
      if (dut.cnt !== 7'd0) begin
         n_bad++; $display("FAIL reset_cnt got=%0d want=0", dut.cnt);
      end
      n_total++;
      if (dut.rptr !== 6'd0) begin
         n_bad++; $display("FAIL reset_rptr got=%0d want=0", dut.rptr);
      end
      n_total++;
      if (rw_eq !== 1'b1) begin
         n_bad++; $display("FAIL reset_rweq got=%b want=1", rw_eq);
      end
      n_total++;
      if (input_valid !== 1'b1) begin
         n_bad++; $display("FAIL reset_valid_zero_pat got=%b want=1", input_valid);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_level();
      logic [3:0] pats [4];
      logic       want [4];
      pats = '{4'b0101, 4'b0100, 4'b0000, 4'b1000};
      want = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_clear(1'b1);
      for (int i = 0; i < 4; i++) begin
         pattern = pats[i];
         #1;
         n_total++;
         if (input_valid !== want[i]) begin
            n_bad++; $display("FAIL level1_valid pat=%b got=%b want=%b", pats[i], input_valid, want[i]);
         end
      end
      do_clear(1'b0);
      pattern = 4'b0101;
      #1;
      n_total++;
      if (input_valid !== 1'b1) begin
         n_bad++; $display("FAIL level0_valid got=%b want=1", input_valid);
      end
   endtask

   task automatic test_single();
      do_clear(1'b0);
      write_entry(4'b0010, 0);
      st          = 2'd1;
      mux_control = 1'b1;
      #1;
      n_total++;
      if (pad_leds !== 4'b0010) begin
         n_bad++; $display("FAIL single_leds got=%b want=0010", pad_leds);
      end
      n_total++;
      if (rw_eq !== 1'b1) begin
         n_bad++; $display("FAIL single_rweq got=%b want=1", rw_eq);
      end
      next_cycle();
      n_total++;
      if (dut.rptr !== 6'd0) begin
         n_bad++; $display("FAIL single_rptr got=%0d want=0", dut.rptr);
      end
   endtask

   task automatic test_game();
      logic [3:0] got;
      do_clear(1'b0);
      for (int r = 0; r < 3; r++) begin
         write_entry(4'd1 << r, r);
         // playback: expect mem[0..r] in order, RWeq only on the last cycle
         for (int i = 0; i <= r; i++) exp_q.push_back(m_mem[i]);
         st = 2'd1; mux_control = 1'b1;
         for (int i = 0; i <= r; i++) begin
            #1;
            n_total++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL game_play_q_empty round=%0d", r);
            end else begin
               got = exp_q.pop_front();
               if (pad_leds !== got) begin
                  n_bad++; $display("FAIL game_play r=%0d i=%0d got=%b want=%b", r, i, pad_leds, got);
               end
            end
            n_total++;
            if (rw_eq !== (i == r)) begin
               n_bad++; $display("FAIL game_rweq r=%0d i=%0d got=%b want=%b", r, i, rw_eq, (i == r));
            end
            next_cycle();
         end
         n_total++;
         if (dut.rptr !== 6'd0) begin
            n_bad++; $display("FAIL game_rptr_after_play r=%0d got=%0d want=0", r, dut.rptr);
         end
         // repeat: player echoes every entry correctly
         st = 2'd2; mux_control = 1'b0;
         for (int i = 0; i <= r; i++) begin
            pattern  = m_mem[i];
            increase = (i == r);
            #1;
            n_total++;
            if (input_eq_pat !== 1'b1) begin
               n_bad++; $display("FAIL game_eq r=%0d i=%0d got=%b want=1", r, i, input_eq_pat);
            end
            next_cycle();
         end
         increase = 1'b0;
         n_total++;
         if (dut.cnt !== 7'(r + 1)) begin
            n_bad++; $display("FAIL game_cnt r=%0d got=%0d want=%0d", r, dut.cnt, r + 1);
         end
      end
   endtask

   task automatic test_mismatch();
      logic [3:0] got;
      // continues from cnt=3 with mem = 1,2,4
      write_entry(4'd8, 3);
      st = 2'd2;
      pattern = m_mem[0];
      next_cycle();
      pattern = 4'hF;
      #1;
      n_total++;
      if (input_eq_pat !== 1'b0) begin
         n_bad++; $display("FAIL mism_eq got=%b want=0", input_eq_pat);
      end
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         n_total++;
         if (dut.rptr !== 6'd1) begin
            n_bad++; $display("FAIL mism_rptr_hold k=%0d got=%0d want=1", k, dut.rptr);
         end
      end
      // done mode replays from the failing index and wraps through cnt
      for (int i = 0; i < 6; i++) exp_q.push_back(m_mem[(1 + i) % 4]);
      st = 2'd3; mux_control = 1'b1; done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_total++;
         if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL done_q_empty i=%0d", i);
         end else begin
            got = exp_q.pop_front();
            if (pad_leds !== got) begin
               n_bad++; $display("FAIL done_replay i=%0d got=%b want=%b", i, pad_leds, got);
            end
         end
         next_cycle();
         done = 1'b0;
      end
   endtask

   task automatic test_full();
      logic [3:0] vals [4];
      vals = '{4'd3, 4'd5, 4'd6, 4'd9};
      do_clear(1'b0);
      for (int r = 0; r < 4; r++) begin
         write_entry(vals[r], r);
         st = 2'd2; increase = 1'b1;
         next_cycle();
         increase = 1'b0;
      end
      n_total++;
      if (dut_s.cnt !== 3'd4) begin
         n_bad++; $display("FAIL full_cnt got=%0d want=4", dut_s.cnt);
      end
      st = 2'd0; pattern = 4'hA; w_en = 1'b1; mux_control = 1'b1;
      #1;
      n_total++;
      if (s_input_valid !== 1'b0) begin
         n_bad++; $display("FAIL full_valid got=%b want=0", s_input_valid);
      end
      n_total++;
      if (input_valid !== 1'b1) begin
         n_bad++; $display("FAIL big_not_full_valid got=%b want=1", input_valid);
      end
      next_cycle();
      w_en = 1'b0;
      #1;
      n_total++;
      if (s_pad_leds !== vals[0]) begin
         n_bad++; $display("FAIL full_no_write got=%b want=%b", s_pad_leds, vals[0]);
      end
      st = 2'd2; increase = 1'b1;
      next_cycle();
      increase = 1'b0;
      n_total++;
      if (dut_s.cnt !== 3'd4) begin
         n_bad++; $display("FAIL full_saturate got=%0d want=4", dut_s.cnt);
      end
   endtask

   task automatic test_async_reset();
      do_clear(1'b0);
      write_entry(4'd1, 0);
      st = 2'd2; increase = 1'b1; next_cycle(); increase = 1'b0;
      write_entry(4'd2, 1);
      st = 2'd2; increase = 1'b1; next_cycle(); increase = 1'b0;
      st = 2'd1; mux_control = 1'b1;
      next_cycle();
      n_total++;
      if (dut.rptr !== 6'd1 || dut.cnt !== 7'd2) begin
         n_bad++; $display("FAIL arst_pre got rptr=%0d cnt=%0d want rptr=1 cnt=2", dut.rptr, dut.cnt);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (dut.rptr !== 6'd0 || dut.cnt !== 7'd0) begin
         n_bad++; $display("FAIL arst_regs got rptr=%0d cnt=%0d want 0 0", dut.rptr, dut.cnt);
      end
      n_total++;
      if (rw_eq !== 1'b1) begin
         n_bad++; $display("FAIL arst_rweq got=%b want=1", rw_eq);
      end
      next_cycle();
      rst_n = 1'b1;
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_level();
      test_single();
      test_game();
      test_mismatch();
      test_full();
      test_async_reset();
      n_total++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/simon_datapath.md
# simon_datapath

Datapath stage for the Simon game, driven cycle-by-cycle by the Simon control FSM. It stores the growing pattern sequence, runs the read pointer through playback, repeat and done modes, and returns the three status flags the controller branches on: `InputValid`, `RWeq` and `InputEqPat`. It also drives the four pad LEDs, either from the switches or from pattern memory.

## Interface
Parameters:
- `WIDTH`, 4: pattern width; one bit per switch and per pad LED.
- `DEPTH`, 64: maximum pattern length (power of two). `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; one edge per game step.
- `rst_n`  in  1  asynchronous, active-low reset.
- `level`  in  1  difficulty: 0 = any pattern is legal, 1 = only one-hot patterns are legal.
- `pattern`  in  WIDTH  switch value from the player.
- `mux_control`  in  1  LED source select: 0 = `pattern`, 1 = memory.
- `st`  in  2  controller mode: 0 input, 1 playback, 2 repeat, 3 done.
- `clear`  in  1  synchronous game clear.
- `increase`  in  1  round passed; advance the stored-entry count.
- `w_en`  in  1  write permission in input mode.
- `done`  in  1  game-over pulse; informational only, no internal effect.
- `InputValid`  out  1  current `pattern` is legal and memory is not full.
- `RWeq`  out  1  read pointer equals the last written index.
- `InputEqPat`  out  1  `pattern == mem[rptr]`.
- `pad_leds`  out  WIDTH  LED drive.

## Operation
- State registers:
  - `cnt` [AW:0]: number of entries in the current round minus one. Write address is `cnt[AW-1:0]`.
  - `rptr` [AW-1:0]: read pointer.
  - `lvl_q`: latched difficulty level.
  - Pattern memory: DEPTH × WIDTH, asynchronous read, synchronous write, **not** reset.
- `rst_n` low: `cnt`, `rptr` and `lvl_q` go to 0 immediately.
- `clear` high at an edge: `cnt <= 0`, `rptr <= 0`, `lvl_q <= level`. `clear` takes priority over every other update.
- `InputValid = (cnt < DEPTH) && (lvl_q ? $onehot(pattern) : 1)`. An all-zero pattern is illegal when `lvl_q` = 1.
- `RWeq = (rptr == cnt[AW-1:0])`.
- `InputEqPat = (pattern == mem[rptr])`.
- `pad_leds = mux_control ? mem[rptr] : pattern`.
- Edge updates, selected by `st`:
  - st=0 (input): if `w_en && InputValid`, write `pattern` to `mem[cnt]`. `rptr <= 0`.
  - st=1 (playback): `rptr <= RWeq ? 0 : rptr+1`.
  - st=2 (repeat):
    - If `increase`: `rptr <= 0` and `cnt <= cnt+1`.
    - Else if `InputEqPat`: `rptr <= rptr+1`.
    - Else: `rptr` holds.
  - st=3 (done): `rptr <= RWeq ? 0 : rptr+1`. The stored sequence replays indefinitely.
- Full memory: when `cnt == DEPTH`, `InputValid` is 0 and no write occurs, so the game halts in input mode (the win condition). An `increase` arriving while `cnt == DEPTH` is ignored and `cnt` saturates.

## Timing
- All flags and `pad_leds` are combinational from the registers and inputs; there is no added latency. The controller samples them at the same edge.
- A write in input mode is visible on `mem[cnt]` in the following cycle.
- Playback of a round with `cnt = k` lasts k+1 cycles and shows `mem[0]` through `mem[k]`. `RWeq` is high in the last cycle, and `rptr` is 0 on entry to repeat.
- Repeat: one `pattern` entry is compared per edge. On a mismatch, `rptr` freezes at the failing index, so done-mode replay starts from there and wraps through `cnt`.
- Reset mid-game: asynchronous; outputs reflect `cnt = rptr = 0` within the same cycle. Memory contents are stale but unreachable until rewritten.

## Structure
- `simon_pkg`: `st` encodings (`ST_INPUT`, `ST_PLAYBACK`, `ST_REPEAT`, `ST_DONE`) and the LED mode constants shared with the controller.
- Sub-module `simon_pattern_mem`: parameterized DEPTH × WIDTH memory, one asynchronous read port and one synchronous write port.
- The top level holds the counters, flag logic and LED mux.

## Test plan
- Reset, then `clear` with `level`=1: `pattern`=4'b0101 gives `InputValid`=0; `pattern`=4'b0100 gives `InputValid`=1; `pattern`=0 gives `InputValid`=0.
- Write 4'b0010 at st=0, then st=1 for 1 cycle: `pad_leds`=4'b0010 and `RWeq`=1; `rptr` returns to 0.
- Three-round game with entries 1, 2, 4, every repeat correct: `cnt` goes 0→1→2→3, and each playback lasts cnt+1 cycles showing memory in order.
- Repeat with a wrong second entry: `InputEqPat`=0 at `rptr`=1 and `rptr` holds. At st=3, `pad_leds` cycles `mem[1]`, …, `mem[cnt]`, `mem[0]`, ….
- With `DEPTH`=4, complete 4 rounds: `cnt`=4, `InputValid`=0, no write occurs, and an extra `increase` leaves `cnt`=4.
- Assert `rst_n` low mid-playback: `rptr`=0 and `cnt`=0 asynchronously, before the next edge.
